// File: rtl/uart_burst_sender_pkg.sv
// Shared types and constants for the UART burst sender and related
// UART front-end blocks.
package uart_burst_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    BAUD_9600,
    BAUD_19200,
    BAUD_57600,
    BAUD_115200
  } baud_sel_t;

  localparam int unsigned DEF_HOLDOFF_CYC = 25_000_000;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_burst_sender_if.sv
// req/busy handshake between a byte sequencer and the UART TX core.
interface uart_burst_sender_if;

  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (
    output tx_req,
    output tx_data,
    input  tx_busy
  );

  modport slave (
    input  tx_req,
    input  tx_data,
    output tx_busy
  );

endinterface

// File: rtl/uart_burst_sender_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous button level, plus a
// one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic w_clk,
  input  logic w_resetn,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/uart_burst_sender.sv
// Burst sequencer: latches an NBYTES payload on a start edge and feeds
// it byte by byte to the UART TX core, with gap, ack timeout and holdoff.
module uart_burst_sender
  import uart_burst_sender_pkg::*;
#(
  parameter int NBYTES      = 4,
  parameter int GAP_CYC     = 0,
  parameter int ACK_TIMEOUT = 16,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic                      w_clk,
  input  logic                      w_resetn,
  input  logic                      start,
  input  logic                      repeat_en,
  input  logic [NBYTES*8-1:0]       payload,
  uart_burst_sender_if.master       tx,
  output logic                      busy,
  output logic                      done,
  output logic                      err_timeout,
  output logic [$clog2(NBYTES):0]   byte_idx
);

  localparam int IW = $clog2(NBYTES) + 1;
  localparam int M1 = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
  localparam int MX = (M1 > HOLDOFF_CYC) ? M1 : HOLDOFF_CYC;
  localparam int CW = cnt_w(MX);

  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NBYTES - 1);
  localparam bit            HAS_GAP   = (GAP_CYC > 0);

  logic start_lvl;
  logic start_rise;

  sync_edge_detect u_sync (
    .w_clk    (w_clk),
    .w_resetn (w_resetn),
    .din      (start),
    .level    (start_lvl),
    .rise     (start_rise)
  );

  state_t              state, state_n;
  logic [NBYTES*8-1:0] shadow, shadow_n;
  logic [NBYTES*8-1:0] shifted;
  logic [IW-1:0]       idx_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                req_n;
  logic [7:0]          data_n;
  logic                busy_n;
  logic                done_n;
  logic                err_n;
  logic                go;

  assign shifted = shadow >> {byte_idx, 3'b000};

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      byte_idx    <= '0;
      cnt         <= '0;
      tx.tx_req   <= 1'b0;
      tx.tx_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      shadow      <= shadow_n;
      byte_idx    <= idx_n;
      cnt         <= cnt_n;
      tx.tx_req   <= req_n;
      tx.tx_data  <= data_n;
      busy        <= busy_n;
      done        <= done_n;
      err_timeout <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    idx_n    = byte_idx;
    cnt_n    = cnt;
    req_n    = 1'b0;
    data_n   = tx.tx_data;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err_timeout;
    go       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        go = start_rise;
      end
      ST_REQ: begin
        req_n   = 1'b1;
        data_n  = shifted[7:0];
        cnt_n   = '0;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx.tx_busy) begin
          state_n = ST_WAIT_DONE;
        end else if (cnt == ACK_LAST) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = ST_HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx.tx_busy) begin
          cnt_n = '0;
          if (byte_idx == IDX_LAST) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_HOLD;
          end else begin
            idx_n   = byte_idx + 1'b1;
            state_n = HAS_GAP ? ST_GAP : ST_REQ;
          end
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_REQ;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        // Edges seen here are dropped; only a held start can relaunch.
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          go      = repeat_en & start_lvl;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (go) begin
      shadow_n = payload;
      idx_n    = '0;
      err_n    = 1'b0;
      busy_n   = 1'b1;
      state_n  = ST_REQ;
    end
  end

endmodule

// File: tb/tb_uart_burst_sender.sv
// Directed bench for uart_burst_sender with a behavioural TX core
// (busy one cycle after req, 20 cycles long).
module tb_uart_burst_sender;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        rep = 1'b0;
  logic [31:0] payload = 32'h0;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  idx;

  uart_burst_sender_if bif ();

  uart_burst_sender #(
    .NBYTES      (4),
    .GAP_CYC     (5),
    .ACK_TIMEOUT (16),
    .HOLDOFF_CYC (100)
  ) dut (
    .w_clk       (clk),
    .w_resetn    (rstn),
    .start       (start),
    .repeat_en   (rep),
    .payload     (payload),
    .tx          (bif),
    .busy        (busy),
    .done        (done),
    .err_timeout (err),
    .byte_idx    (idx)
  );

  always #5 clk = ~clk;

  logic       mbusy = 1'b0;
  logic       mute = 1'b0;
  int         mcnt = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  logic [7:0] q[$];
  int         req_t[$];

  assign bif.tx_busy = mbusy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif.tx_req) req_t.push_back(cyc);
    if (done) done_cnt <= done_cnt + 1;
    if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mbusy <= 1'b0;
    end else if (bif.tx_req && !mute) begin
      mbusy <= 1'b1;
      mcnt  <= 20;
      q.push_back(bif.tx_data);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic chk_bytes(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = '0;
    for (int i = 0; i < 4 && i < q.size(); i++) got[8*i +: 8] = q[i];
    chk({tag, "_n"}, q.size(), 4);
    chk(tag, got, exp);
  endtask

  initial begin
    int n;
    int r0;
    int d0;
    logic hold_ok;
    logic bsy_ok;

    tick(2);
    chk("rst_req", bif.tx_req, 0);
    chk("rst_data", bif.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_idx", idx, 0);
    rstn = 1'b1;
    tick(2);

    // basic burst, latency, gap timing, payload shadowing
    payload = 32'hDDCCBBAA;
    start = 1'b1;
    tick(3);
    chk("lat3", bif.tx_req, 0);
    tick(1);
    chk("lat4", bif.tx_req, 1);
    chk("data0", bif.tx_data, 8'hAA);
    chk("busy_on", busy, 1);
    start = 1'b0;
    payload = 32'h11223344;
    n = 0;
    while (!mbusy && n < 10) begin
      tick(1);
      n++;
    end
    hold_ok = 1'b1;
    while (mbusy && n < 60) begin
      if (bif.tx_data !== 8'hAA) hold_ok = 1'b0;
      tick(1);
      n++;
    end
    chk("data_hold", hold_ok, 1);
    n = 0;
    bsy_ok = 1'b1;
    while (!bif.tx_req && n < 50) begin
      if (!busy) bsy_ok = 1'b0;
      tick(1);
      n++;
    end
    chk("gap_cyc", n, 7);
    chk("gap_busy", bsy_ok, 1);
    chk("data1", bif.tx_data, 8'hBB);
    wait_done("t1_done");
    chk("t1_busy", busy, 0);
    tick(1);
    chk("done_pulse", done, 0);
    chk_bytes("t1_bytes", 32'hDDCCBBAA);
    chk("t1_reqs", req_t.size(), 4);
    chk("t1_dcnt", done_cnt, 1);
    tick(110);

    // ack timeout
    mute = 1'b1;
    d0 = done_cnt;
    start = 1'b1;
    tick(4);
    chk("t3_req", bif.tx_req, 1);
    tick(15);
    chk("t3_err15", err, 0);
    tick(1);
    chk("t3_err16", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_done", done_cnt - d0, 0);
    mute = 1'b0;
    start = 1'b0;
    tick(110);
    chk("t3_sticky", err, 1);
    start = 1'b1;
    tick(3);
    chk("t3_clr", err, 0);
    chk("t3_busy2", busy, 1);
    start = 1'b0;
    wait_done("t3_done2");
    tick(110);

    // ignored edges during burst and holdoff
    r0 = req_t.size();
    d0 = done_cnt;
    start = 1'b1;
    tick(10);
    start = 1'b0;
    tick(5);
    start = 1'b1;
    tick(5);
    start = 1'b0;
    wait_done("t4_done");
    tick(3);
    start = 1'b1;
    tick(110);
    chk("t4_reqs", req_t.size() - r0, 4);
    chk("t4_dcnt", done_cnt - d0, 1);
    chk("t4_idle", busy, 0);
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick(4);
    chk("t4_relaunch", bif.tx_req, 1);
    start = 1'b0;
    wait_done("t4_done2");
    tick(110);

    // auto-repeat with payload resampling
    q.delete();
    req_t.delete();
    payload = 32'h44332211;
    rep = 1'b1;
    start = 1'b1;
    wait_done("t5_done1");
    payload = 32'h88776655;
    tick(1);
    wait_done("t5_done2");
    start = 1'b0;
    rep = 1'b0;
    chk("t5_n", q.size(), 8);
    if (q.size() == 8) begin
      chk("t5_b0", {q[3], q[2], q[1], q[0]}, 32'h44332211);
      chk("t5_b1", {q[7], q[6], q[5], q[4]}, 32'h88776655);
    end
    if (req_t.size() >= 5) chk("t5_period", req_t[4] - req_t[0], 207);
    else chk("t5_period", req_t.size(), 5);
    tick(120);
    chk("t5_stop", req_t.size(), 8);

    // reset in the middle of a burst
    payload = 32'hDDCCBBAA;
    start = 1'b1;
    n = 0;
    while (!(bif.tx_req && idx == 3'd1) && n < 200) begin
      tick(1);
      n++;
    end
    chk("t6_arm", idx, 1);
    rstn = 1'b0;
    start = 1'b0;
    tick(1);
    chk("t6_req", bif.tx_req, 0);
    chk("t6_data", bif.tx_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_idx", idx, 0);
    chk("t6_err", err, 0);
    tick(1);
    rstn = 1'b1;
    tick(30);
    q.delete();
    start = 1'b1;
    tick(4);
    chk("t6_data0", bif.tx_data, 8'hAA);
    start = 1'b0;
    wait_done("t6_done");
    chk_bytes("t6_bytes", 32'hDDCCBBAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
